wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
Writeback stage plus architectural integer register file for the 5-stage RV32I pipeline. It consumes the W-stage control (rf_enW, wb_selW) and W-stage data from the MEM/WB buffers. It selects and load-formats the writeback value, commits it to x1..x31, and serves the two decode-stage read ports with same-cycle write bypass. It also keeps a retired-instruction counter.

Parameters:
XLEN, 32, data width
NREG, 32, number of architectural registers (x0 hardwired zero)
CNTW, 64, width of retired-instruction counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
validW  input  1  W-stage holds a real (non-bubble) instruction
rf_enW  input  1  register-file write enable from MEM/WB control buffer
wb_selW  input  2  writeback source select
rdW  input  5  destination register index
alu_resW  input  XLEN  ALU result; low 2 bits also give the load byte offset
mem_rdataW  input  XLEN  raw 32-bit word read from data memory
funct3W  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
pc4W  input  XLEN  PC+4 of the W instruction
csr_rdataW  input  XLEN  CSR read data
rs1D  input  5  decode read index 1
rs2D  input  5  decode read index 2
rdata1D  output  XLEN  read data port 1 (combinational)
rdata2D  output  XLEN  read data port 2 (combinational)
wdataW  output  XLEN  selected writeback value (to forwarding mux)
wr_fireW  output  1  a register write commits this cycle
instret  output  CNTW  count of retired instructions

Behaviour:
- wb_selW encoding: 00 alu_resW, 01 formatted load, 10 pc4W, 11 csr_rdataW.
- Load formatting uses off = alu_resW[1:0]:
  - LB/LBU: byte at off, sign- or zero-extended.
  - LH/LHU: halfword at off[1] (off[0] ignored; misalignment is trapped upstream), sign- or zero-extended.
  - LW: full word.
  - Other funct3 values: full word.
- wdataW is combinational on the current W inputs, regardless of validW.
- wr_fireW = validW & rf_enW & (rdW != 0).
- On the posedge with wr_fireW=1: reg[rdW] <= wdataW.
- Writes to x0 are discarded; reads of x0 always return 0.
- Read ports are combinational:
  - rdataND = 0 if rsND==0.
  - Else wdataW if wr_fireW & (rsND==rdW) (write-first bypass, same cycle).
  - Else reg[rsND].
- Both read ports may hit the same register and the bypass simultaneously; both then return wdataW.
- instret increments by 1 on every posedge with validW=1, independent of rf_enW.
- instret wraps from all-ones to 0 with no flag.
- Reset (rst high at posedge): reg[1..31] <= 0, instret <= 0.
- Reset has priority over any write or increment in the same cycle.
- Reset mid-stream drops the W instruction: no write, no count.
- Outputs during reset:
  - rdata1D/rdata2D still follow the combinational rule; the bypass is still active because wr_fireW is not gated by rst.
  - Register state still does not change.
- Latency: a write is visible through the bypass in the same cycle and from storage on the following cycle.
- No stall input: the WB stage never stalls, so upstream holds bubbles with validW=0.

Decomposition:
- Shared package (riscv_pkg):
  - wb_sel_e enum: WB_ALU, WB_MEM, WB_PC4, WB_CSR.
  - Load funct3 constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - XLEN default.
- One sub-module, load_formatter: combinational word + offset + funct3 -> extended XLEN value.
- The mux, register array, bypass and counter stay in wb_regfile.

Test Plan:
- Reset, then read all 32 indices on both ports -> all 0; instret=0.
- validW=1, rf_enW=1, wb_selW=00, rdW=5, alu_resW=32'hDEAD_BEEF, rs1D=5 in the same cycle -> rdata1D=DEADBEEF via bypass; next cycle with no write, rs2D=5 -> DEADBEEF; instret=1.
- Load formatting, mem_rdataW=32'h80FF_7F01, wb_selW=01:
  - LB off=3 -> FFFFFF80
  - LBU off=3 -> 00000080
  - LH off=2 -> FFFF80FF
  - LHU off=0 -> 00007F01
  - LW -> 80FF7F01
- Write to rdW=0 with value 1234 -> wr_fireW=0, rdata1D(rs1D=0)=0 in the same and next cycle; instret still increments.
- Bubble: validW=0, rf_enW=1, rdW=7 -> wr_fireW=0, x7 unchanged, instret unchanged.
- rst asserted in the same cycle as a write to x9=55 with validW=1 -> after the edge x9=0, instret=0; with instret preloaded to all-ones (via 2^64-1 retirements, or a force in the bench), one more retirement -> instret=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I pipeline: writeback select encoding,
// load funct3 codes and the default data width.
package riscv_pkg;

  localparam int XLEN_DEF = 32;

  // Writeback source select carried in the MEM/WB control buffer
  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_CSR = 2'b11
  } wb_sel_e;

  // Load-type funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // True for the load types that sign-extend their result
  function automatic logic is_signed_load(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH);
  endfunction

endpackage

// File: rtl/wb_regfile_load_formatter.sv
// Load formatter: picks the addressed byte/halfword out of the raw memory
// word and sign- or zero-extends it to XLEN. Purely combinational.
module load_formatter
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [31:0]     word_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext;

  // Lane selection; off_i[0] is ignored for halfwords since misaligned
  // accesses never reach this stage.
  always_comb begin
    byte_sel = word_i[7:0];
    case (off_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      2'd3: byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
  end

  assign sext = is_signed_load(funct3_i);

  // Extension by load type; unknown funct3 values pass the full word
  always_comb begin
    data_o = XLEN'($signed(word_i));
    case (funct3_i)
      F3_LB, F3_LBU: data_o = sext ? XLEN'($signed(byte_sel)) : XLEN'(byte_sel);
      F3_LH, F3_LHU: data_o = sext ? XLEN'($signed(half_sel)) : XLEN'(half_sel);
      F3_LW:         data_o = XLEN'($signed(word_i));
      default:       data_o = XLEN'($signed(word_i));
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage and architectural integer register file. Selects the
// writeback value, commits it to x1..x(NREG-1), serves two decode read
// ports with same-cycle write bypass, and counts retired instructions.
module wb_regfile
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = 32,
  parameter int CNTW = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            validW,
  input  logic            rf_enW,
  input  logic [1:0]      wb_selW,
  input  logic [4:0]      rdW,
  input  logic [XLEN-1:0] alu_resW,
  input  logic [XLEN-1:0] mem_rdataW,
  input  logic [2:0]      funct3W,
  input  logic [XLEN-1:0] pc4W,
  input  logic [XLEN-1:0] csr_rdataW,
  input  logic [4:0]      rs1D,
  input  logic [4:0]      rs2D,
  output logic [XLEN-1:0] rdata1D,
  output logic [XLEN-1:0] rdata2D,
  output logic [XLEN-1:0] wdataW,
  output logic            wr_fireW,
  output logic [CNTW-1:0] instret
);

  logic [XLEN-1:0] load_val;
  wb_sel_e         wb_sel;

  // x0 has no storage; index 0 is resolved in the read logic
  logic [XLEN-1:0] rf_q [1:NREG-1];
  logic [CNTW-1:0] instret_q;
  logic [CNTW-1:0] instret_d;

  load_formatter #(
    .XLEN (XLEN)
  ) u_fmt (
    .word_i   (mem_rdataW[31:0]),
    .off_i    (alu_resW[1:0]),
    .funct3_i (funct3W),
    .data_o   (load_val)
  );

  assign wb_sel = wb_sel_e'(wb_selW);

  // Writeback source mux; independent of validW so forwarding sees it early
  always_comb begin
    wdataW = alu_resW;
    case (wb_sel)
      WB_ALU:  wdataW = alu_resW;
      WB_MEM:  wdataW = load_val;
      WB_PC4:  wdataW = pc4W;
      WB_CSR:  wdataW = csr_rdataW;
      default: wdataW = alu_resW;
    endcase
  end

  // Deliberately not gated by rst: the bypass stays live during reset
  assign wr_fireW = validW & rf_enW & (rdW != 5'd0);

  // One storage word per architectural register, each with its own decode
  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_reg
      // Reset clears the register; otherwise capture a write addressed here
      always_ff @(posedge clk) begin
        if (rst) begin
          rf_q[gi] <= '0;
        end else if (wr_fireW && (rdW == 5'(gi))) begin
          rf_q[gi] <= wdataW;
        end
      end
    end
  endgenerate

  // Two identical read ports: x0 -> 0, then write-first bypass, then storage
  logic [4:0]      rs_idx  [2];
  logic [XLEN-1:0] rd_data [2];

  assign rs_idx[0] = rs1D;
  assign rs_idx[1] = rs2D;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rport
      // Combinational read with same-cycle bypass of the committing write
      always_comb begin
        rd_data[gi] = '0;
        if (rs_idx[gi] == 5'd0) begin
          rd_data[gi] = '0;
        end else if (wr_fireW && (rs_idx[gi] == rdW)) begin
          rd_data[gi] = wdataW;
        end else begin
          rd_data[gi] = rf_q[rs_idx[gi]];
        end
      end
    end
  endgenerate

  assign rdata1D = rd_data[0];
  assign rdata2D = rd_data[1];

  // Retired-instruction count; wraps silently at all-ones
  always_comb begin
    instret_d = instret_q;
    if (validW) begin
      instret_d = instret_q + CNTW'(1);
    end
  end

  // Counter register; reset wins over a retirement in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus a randomized
// run against a behavioural register-file model. A second instance with a
// 4-bit counter exercises counter wrap.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        validW, rf_enW;
  logic [1:0]  wb_selW;
  logic [4:0]  rdW, rs1D, rs2D;
  logic [31:0] alu_resW, mem_rdataW, pc4W, csr_rdataW;
  logic [2:0]  funct3W;
  logic [31:0] rdata1D, rdata2D, wdataW;
  logic        wr_fireW;
  logic [63:0] instret;
  logic [31:0] rdata1D_w, rdata2D_w, wdataW_w;
  logic        wr_fireW_w;
  logic [3:0]  instret_w;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_rf [32];
  logic [63:0] m_cnt;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst), .validW(validW), .rf_enW(rf_enW), .wb_selW(wb_selW),
    .rdW(rdW), .alu_resW(alu_resW), .mem_rdataW(mem_rdataW), .funct3W(funct3W),
    .pc4W(pc4W), .csr_rdataW(csr_rdataW), .rs1D(rs1D), .rs2D(rs2D),
    .rdata1D(rdata1D), .rdata2D(rdata2D), .wdataW(wdataW), .wr_fireW(wr_fireW),
    .instret(instret)
  );

  wb_regfile #(.CNTW(4)) dut_w (
    .clk(clk), .rst(rst), .validW(validW), .rf_enW(rf_enW), .wb_selW(wb_selW),
    .rdW(rdW), .alu_resW(alu_resW), .mem_rdataW(mem_rdataW), .funct3W(funct3W),
    .pc4W(pc4W), .csr_rdataW(csr_rdataW), .rs1D(rs1D), .rs2D(rs2D),
    .rdata1D(rdata1D_w), .rdata2D(rdata2D_w), .wdataW(wdataW_w), .wr_fireW(wr_fireW_w),
    .instret(instret_w)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] f3);
    logic [31:0] b, h;
    b = w >> (8 * off);
    h = w >> (off[1] ? 16 : 0);
    case (f3)
      3'b000:  return {{24{b[7]}}, b[7:0]};
      3'b100:  return {24'd0, b[7:0]};
      3'b001:  return {{16{h[15]}}, h[15:0]};
      3'b101:  return {16'd0, h[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata();
    case (wb_selW)
      2'd0:    return alu_resW;
      2'd1:    return ref_load(mem_rdataW, alu_resW[1:0], funct3W);
      2'd2:    return pc4W;
      default: return csr_rdataW;
    endcase
  endfunction

  function automatic logic ref_fire();
    return validW && rf_enW && (rdW != 5'd0);
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
    if (ref_fire() && rs == rdW) return ref_wdata();
    return m_rf[rs];
  endfunction

  // Drive a full W-stage input set (no checking)
  task automatic drive(input logic v, input logic en, input logic [1:0] sel,
                       input logic [4:0] rd, input logic [31:0] alu);
    validW = v; rf_enW = en; wb_selW = sel; rdW = rd; alu_resW = alu;
  endtask

  // Advance one clock and update the model from the inputs seen at the edge
  task automatic tick();
    logic [31:0] wd;
    logic        fire;
    wd = ref_wdata();
    fire = ref_fire();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      m_cnt = 64'd0;
    end else begin
      if (validW) m_cnt = m_cnt + 64'd1;
      if (fire) m_rf[rdW] = wd;
    end
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0);
    mem_rdataW = 32'd0; funct3W = 3'd2; pc4W = 32'd0; csr_rdataW = 32'd0;
    rs1D = 5'd0; rs2D = 5'd0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1D = 5'(i); rs2D = 5'(31 - i);
      #1;
      checks++;
      if (rdata1D !== 32'd0) begin
        errors++; $display("FAIL reset_rd1 x%0d: got %h expected 00000000", i, rdata1D);
      end
      checks++;
      if (rdata2D !== 32'd0) begin
        errors++; $display("FAIL reset_rd2 x%0d: got %h expected 00000000", 31 - i, rdata2D);
      end
    end
    checks++;
    if (instret !== 64'd0) begin
      errors++; $display("FAIL reset_instret: got %0d expected 0", instret);
    end
    $display("test_reset: done");
  endtask

  task automatic test_bypass();
    drive(1'b1, 1'b1, 2'd0, 5'd5, 32'hDEAD_BEEF);
    rs1D = 5'd5; rs2D = 5'd0;
    #1;
    checks++;
    if (rdata1D !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL bypass_rd1: got %h expected deadbeef", rdata1D);
    end
    checks++;
    if (wr_fireW !== 1'b1) begin
      errors++; $display("FAIL bypass_fire: got %b expected 1", wr_fireW);
    end
    tick();
    drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0);
    rs1D = 5'd0; rs2D = 5'd5;
    #1;
    checks++;
    if (rdata2D !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL stored_rd2: got %h expected deadbeef", rdata2D);
    end
    checks++;
    if (instret !== 64'd1) begin
      errors++; $display("FAIL bypass_instret: got %0d expected 1", instret);
    end
    $display("test_bypass: x5 written and read back");
  endtask

  task automatic test_load_format();
    logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  offs [5] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0};
    logic [31:0] exps [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                              32'h0000_7F01, 32'h80FF_7F01};
    mem_rdataW = 32'h80FF_7F01;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 2'd1, 5'd0, {$urandom_range(0, 1023), offs[i]} & 32'h0000_0FFF);
      funct3W = f3s[i];
      #1;
      checks++;
      if (wdataW !== exps[i]) begin
        errors++;
        $display("FAIL load_fmt f3=%b off=%0d: got %h expected %h", f3s[i], offs[i], wdataW, exps[i]);
      end
      $display("test_load_format: f3=%b off=%0d wdata=%h", f3s[i], offs[i], wdataW);
    end
  endtask

  task automatic test_x0_write();
    logic [63:0] cnt0;
    cnt0 = m_cnt;
    drive(1'b1, 1'b1, 2'd0, 5'd0, 32'd1234);
    rs1D = 5'd0;
    #1;
    checks++;
    if (wr_fireW !== 1'b0) begin
      errors++; $display("FAIL x0_fire: got %b expected 0", wr_fireW);
    end
    checks++;
    if (rdata1D !== 32'd0) begin
      errors++; $display("FAIL x0_same: got %h expected 00000000", rdata1D);
    end
    tick();
    drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0);
    #1;
    checks++;
    if (rdata1D !== 32'd0) begin
      errors++; $display("FAIL x0_next: got %h expected 00000000", rdata1D);
    end
    checks++;
    if (instret !== cnt0 + 64'd1) begin
      errors++; $display("FAIL x0_instret: got %0d expected %0d", instret, cnt0 + 64'd1);
    end
    $display("test_x0_write: instret=%0d", instret);
  endtask

  task automatic test_bubble();
    logic [63:0] cnt0;
    drive(1'b1, 1'b1, 2'd2, 5'd7, 32'd0);
    pc4W = 32'h0000_1004;
    tick();
    cnt0 = m_cnt;
    drive(1'b0, 1'b1, 2'd0, 5'd7, 32'h5555_AAAA);
    rs1D = 5'd7;
    #1;
    checks++;
    if (wr_fireW !== 1'b0) begin
      errors++; $display("FAIL bubble_fire: got %b expected 0", wr_fireW);
    end
    checks++;
    if (rdata1D !== 32'h0000_1004) begin
      errors++; $display("FAIL bubble_nobypass: got %h expected 00001004", rdata1D);
    end
    tick();
    checks++;
    if (rdata1D !== 32'h0000_1004) begin
      errors++; $display("FAIL bubble_x7: got %h expected 00001004", rdata1D);
    end
    checks++;
    if (instret !== cnt0) begin
      errors++; $display("FAIL bubble_instret: got %0d expected %0d", instret, cnt0);
    end
    $display("test_bubble: x7=%h", rdata1D);
  endtask

  task automatic test_reset_priority();
    rst = 1'b1;
    drive(1'b1, 1'b1, 2'd0, 5'd9, 32'd55);
    rs1D = 5'd9; rs2D = 5'd9;
    #1;
    checks++;
    if (rdata1D !== 32'd55 || rdata2D !== 32'd55) begin
      errors++; $display("FAIL rst_bypass: got %h/%h expected 00000037", rdata1D, rdata2D);
    end
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0);
    #1;
    checks++;
    if (rdata1D !== 32'd0) begin
      errors++; $display("FAIL rst_x9: got %h expected 00000000", rdata1D);
    end
    checks++;
    if (instret !== 64'd0) begin
      errors++; $display("FAIL rst_instret: got %0d expected 0", instret);
    end
    $display("test_reset_priority: x9=%h instret=%0d", rdata1D, instret);
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b0, 2'd0, 5'd3, 32'd0);
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (instret_w !== m_cnt[3:0]) begin
        errors++; $display("FAIL wrap_cnt step %0d: got %0d expected %0d", i, instret_w, m_cnt[3:0]);
      end
    end
    checks++;
    if (instret_w !== 4'd0) begin
      errors++; $display("FAIL wrap_zero: got %0d expected 0", instret_w);
    end
    checks++;
    if (instret !== 64'd16) begin
      errors++; $display("FAIL wrap_wide: got %0d expected 16", instret);
    end
    drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0);
    $display("test_wrap: narrow counter=%0d wide=%0d", instret_w, instret);
  endtask

  task automatic test_random();
    logic [31:0] e;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 31)), $urandom);
      mem_rdataW = $urandom; pc4W = $urandom; csr_rdataW = $urandom;
      funct3W = 3'($urandom_range(0, 7));
      rs1D = ($urandom_range(0, 2) == 0) ? rdW : 5'($urandom_range(0, 31));
      rs2D = ($urandom_range(0, 2) == 0) ? rdW : 5'($urandom_range(0, 31));
      @(negedge clk);
      e = ref_wdata();
      checks++;
      if (wdataW !== e) begin
        errors++; $display("FAIL rnd_wdata #%0d: got %h expected %h", n, wdataW, e);
      end
      checks++;
      if (wr_fireW !== ref_fire()) begin
        errors++; $display("FAIL rnd_fire #%0d: got %b expected %b", n, wr_fireW, ref_fire());
      end
      e = ref_read(rs1D);
      checks++;
      if (rdata1D !== e) begin
        errors++; $display("FAIL rnd_rd1 #%0d rs=%0d: got %h expected %h", n, rs1D, rdata1D, e);
      end
      e = ref_read(rs2D);
      checks++;
      if (rdata2D !== e) begin
        errors++; $display("FAIL rnd_rd2 #%0d rs=%0d: got %h expected %h", n, rs2D, rdata2D, e);
      end
      tick();
      checks++;
      if (instret !== m_cnt || instret_w !== m_cnt[3:0]) begin
        errors++; $display("FAIL rnd_instret #%0d: got %0d/%0d expected %0d", n, instret, instret_w, m_cnt);
      end
      $display("rnd #%0d rst=%b v=%b en=%b rd=%0d wd=%h instret=%0d", n, rst, validW, rf_enW, rdW, wdataW, instret);
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_cnt = 64'd0;
    test_reset();
    test_bypass();
    test_load_format();
    test_x0_write();
    test_bubble();
    test_reset_priority();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
